// File: rtl/jericalla_sequencer.sv
// Program sequencer for the JERICALLA_EVO datapath: a small program RAM stepped through
// on start, with each instruction held on the datapath for HOLD_CYCLES, plus local BZ/HALT.
module jericalla_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int HOLD_CYCLES = 5
) (
  input  logic              clk_jericalla,
  input  logic              rst_n_jericalla,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [17:0]       prog_data,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              zf_jericalla,
  output logic [17:0]       instruccion,
  output logic              instr_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0] OP_BZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    BRANCH,
    DONE
  } state_t;

  state_t             state;
  logic [17:0]        mem [DEPTH];
  logic [HOLD_W-1:0]  hold_cnt;
  logic [17:0]        fetch_word;
  logic [2:0]         fetch_op;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  pc_inc;
  logic               at_last;

  assign fetch_word    = mem[pc];
  assign fetch_op      = fetch_word[17:15];
  assign branch_target = fetch_word[ADDR_W-1:0];
  assign pc_inc        = pc + ADDR_W'(1);
  assign at_last       = (pc == last_addr);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Program RAM is deliberately left unreset so a reset mid-run keeps the loaded program.
  always_ff @(posedge clk_jericalla) begin
    if (prog_we && state == IDLE)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      state       <= IDLE;
      instruccion <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      instr_count <= '0;
      hold_cnt    <= '0;
    end else if (abort && state != IDLE) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            pc          <= '0;
            instr_count <= '0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (fetch_op == OP_HALT) begin
            state <= DONE;
          end else if (fetch_op == OP_BZ) begin
            state <= BRANCH;
          end else begin
            instruccion <= fetch_word;
            instr_valid <= 1'b1;
            instr_count <= instr_count + 8'd1;
            hold_cnt    <= HOLD_LOAD;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (hold_cnt == '0) begin
            instr_valid <= 1'b0;
            if (at_last) begin
              state <= DONE;
            end else begin
              pc    <= pc_inc;
              state <= FETCH;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        BRANCH: begin
          // A taken branch deliberately bypasses the last_addr test.
          if (zf_jericalla) begin
            pc    <= branch_target;
            state <= FETCH;
          end else if (at_last) begin
            state <= DONE;
          end else begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Scoreboard bench for jericalla_sequencer: stimulus pushes expected issues/done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_jericalla_sequencer;

  localparam int ADDR_W = 5;
  localparam int HOLD   = 5;

  localparam logic [17:0] W0    = 18'b000001000000000001;
  localparam logic [17:0] W1    = 18'b001001010000100010;
  localparam logic [17:0] W2    = 18'b010001100001000011;
  localparam logic [17:0] W3    = 18'b011000000011100100;
  localparam logic [17:0] W4    = 18'b100000100001000101;
  localparam logic [17:0] W5    = 18'b101000110001100110;
  localparam logic [17:0] WA    = 18'b010010001100011101;
  localparam logic [17:0] WBAD  = 18'b101111111111111111;
  localparam logic [17:0] HALT  = 18'b111000000000000000;
  localparam logic [17:0] BZ4   = 18'b110000000000000100;
  localparam logic [17:0] BZ31  = 18'b110000000000011111;

  logic              clk_jericalla   = 1'b0;
  logic              rst_n_jericalla = 1'b0;
  logic              prog_we         = 1'b0;
  logic [ADDR_W-1:0] prog_addr       = '0;
  logic [17:0]       prog_data       = '0;
  logic              start           = 1'b0;
  logic              abort           = 1'b0;
  logic [ADDR_W-1:0] last_addr       = '0;
  logic              zf_jericalla    = 1'b0;
  logic [17:0]       instruccion;
  logic              instr_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        instr_count;

  int cyc        = 0;
  int assert_cnt = 0;
  int fail_cnt   = 0;

  typedef struct { logic [17:0] word; int len; } issue_t;
  typedef struct { int at_cyc; int count; } done_t;
  issue_t issue_q[$];
  done_t  done_q[$];

  issue_t cur_issue;
  int     run_len    = 0;
  logic   prev_valid = 1'b0;

  jericalla_sequencer #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clk_jericalla   (clk_jericalla),
    .rst_n_jericalla (rst_n_jericalla),
    .prog_we         (prog_we),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .start           (start),
    .abort           (abort),
    .last_addr       (last_addr),
    .zf_jericalla    (zf_jericalla),
    .instruccion     (instruccion),
    .instr_valid     (instr_valid),
    .busy            (busy),
    .done            (done),
    .pc              (pc),
    .instr_count     (instr_count)
  );

  always #5 clk_jericalla = ~clk_jericalla;
  always @(posedge clk_jericalla) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic load_word(input int addr, input logic [17:0] data);
    prog_we   = 1'b1;
    prog_addr = ADDR_W'(addr);
    prog_data = data;
    @(negedge clk_jericalla);
    prog_we   = 1'b0;
  endtask

  task automatic apply_stimulus(output int c);
    c     = cyc;
    start = 1'b1;
    @(negedge clk_jericalla);
    start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_jericalla);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk_jericalla);
    check_output("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_issue(input logic [17:0] word, input int len);
    issue_t e;
    e.word = word;
    e.len  = len;
    issue_q.push_back(e);
  endtask

  task automatic push_done(input int at_cyc, input int count);
    done_t e;
    e.at_cyc = at_cyc;
    e.count  = count;
    done_q.push_back(e);
  endtask

  // Monitor: each rising instr_valid pops an expected word, each falling edge checks hold length.
  always @(negedge clk_jericalla) begin
    done_t d;
    if (instr_valid && !prev_valid) begin
      if (issue_q.size() == 0) begin
        check_output("unexpected_issue", 32'(instruccion), 32'h3ffff);
      end else begin
        cur_issue = issue_q.pop_front();
        check_output("issue_word", 32'(instruccion), 32'(cur_issue.word));
        run_len = 1;
      end
    end else if (instr_valid) begin
      run_len++;
    end else if (prev_valid) begin
      check_output("hold_length", 32'(run_len), 32'(cur_issue.len));
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check_output("unexpected_done", 32'(done), 32'd0);
      end else begin
        d = done_q.pop_front();
        check_output("done_cycle", 32'(cyc), 32'(d.at_cyc));
        check_output("done_count", 32'(instr_count), 32'(d.count));
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    repeat (2) @(negedge clk_jericalla);
    check_output("rst_instruccion", 32'(instruccion), 32'd0);
    check_output("rst_valid", 32'(instr_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_pc", 32'(pc), 32'd0);
    check_output("rst_count", 32'(instr_count), 32'd0);
    rst_n_jericalla = 1'b1;
    @(negedge clk_jericalla);

    // Straight-line run, with a stray start while busy
    load_word(0, W0); load_word(1, W1); load_word(2, W2); load_word(3, W3);
    last_addr = 3;
    push_issue(W0, HOLD); push_issue(W1, HOLD); push_issue(W2, HOLD); push_issue(W3, HOLD);
    apply_stimulus(c);
    push_done(c + 25, 4);
    wait_until(c + 5);
    start = 1'b1;
    @(negedge clk_jericalla);
    start = 1'b0;
    wait_idle(60);
    check_output("straight_count", 32'(instr_count), 32'd4);
    check_output("straight_pc", 32'(pc), 32'd3);
    check_output("straight_hold_word", 32'(instruccion), 32'(W3));

    // start together with abort in IDLE must not launch a run
    start = 1'b1; abort = 1'b1;
    @(negedge clk_jericalla);
    start = 1'b0; abort = 1'b0;
    check_output("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk_jericalla);
    check_output("start_abort_count", 32'(instr_count), 32'd4);

    // HALT at address 2
    load_word(2, HALT);
    last_addr = 5;
    push_issue(W0, HOLD); push_issue(W1, HOLD);
    apply_stimulus(c);
    push_done(c + 14, 2);
    wait_idle(60);
    check_output("halt_pc", 32'(pc), 32'd2);

    // BZ taken to address 4
    load_word(1, BZ4); load_word(2, W2); load_word(4, W4);
    last_addr = 4;
    zf_jericalla = 1'b1;
    push_issue(W0, HOLD); push_issue(W4, HOLD);
    apply_stimulus(c);
    push_done(c + 15, 2);
    wait_until(c + 8);
    check_output("bzt_branch_valid", 32'(instr_valid), 32'd0);
    check_output("bzt_branch_pc", 32'(pc), 32'd1);
    wait_until(c + 9);
    check_output("bzt_target_pc", 32'(pc), 32'd4);
    wait_idle(60);

    // BZ not taken falls through to address 2
    zf_jericalla = 1'b0;
    push_issue(W0, HOLD); push_issue(W2, HOLD); push_issue(W3, HOLD); push_issue(W4, HOLD);
    apply_stimulus(c);
    push_done(c + 27, 4);
    wait_until(c + 8);
    check_output("bznt_branch_valid", 32'(instr_valid), 32'd0);
    check_output("bznt_branch_busy", 32'(busy), 32'd1);
    wait_until(c + 9);
    check_output("bznt_next_pc", 32'(pc), 32'd2);
    wait_idle(60);

    // Abort on the 3rd EXEC cycle of address 1, then a clean restart
    load_word(1, W1);
    last_addr = 3;
    push_issue(W0, HOLD); push_issue(W1, 3);
    apply_stimulus(c);
    wait_until(c + 10);
    abort = 1'b1;
    @(negedge clk_jericalla);
    abort = 1'b0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_valid", 32'(instr_valid), 32'd0);
    repeat (3) @(negedge clk_jericalla);
    push_issue(W0, HOLD); push_issue(W1, HOLD); push_issue(W2, HOLD); push_issue(W3, HOLD);
    apply_stimulus(c);
    check_output("restart_pc", 32'(pc), 32'd0);
    check_output("restart_count", 32'(instr_count), 32'd0);
    push_done(c + 25, 4);
    wait_idle(60);

    // Write in the start cycle lands; a write while busy is dropped
    push_issue(W5, HOLD); push_issue(W1, HOLD); push_issue(W2, HOLD); push_issue(W3, HOLD);
    c = cyc;
    start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = W5;
    @(negedge clk_jericalla);
    start = 1'b0; prog_we = 1'b0;
    push_done(c + 25, 4);
    wait_until(c + 8);
    load_word(0, WBAD);
    wait_idle(60);

    // Async reset in the middle of address 1
    push_issue(W5, HOLD); push_issue(W1, 3);
    apply_stimulus(c);
    wait_until(c + 10);
    #2 rst_n_jericalla = 1'b0;
    #1;
    check_output("arst_instruccion", 32'(instruccion), 32'd0);
    check_output("arst_valid", 32'(instr_valid), 32'd0);
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_done", 32'(done), 32'd0);
    check_output("arst_pc", 32'(pc), 32'd0);
    check_output("arst_count", 32'(instr_count), 32'd0);
    @(negedge clk_jericalla);
    @(negedge clk_jericalla);
    rst_n_jericalla = 1'b1;
    @(negedge clk_jericalla);

    // Memory survives reset: single instruction run
    last_addr = 0;
    push_issue(W5, HOLD);
    apply_stimulus(c);
    push_done(c + 7, 1);
    wait_idle(60);

    // pc wraps from 31 to 0; BZ at 0 not taken and at last_addr ends the run
    load_word(0, BZ31); load_word(31, WA);
    zf_jericalla = 1'b1;
    push_issue(WA, HOLD);
    apply_stimulus(c);
    push_done(c + 11, 1);
    wait_until(c + 4);
    check_output("wrap_pc31", 32'(pc), 32'd31);
    wait_until(c + 5);
    zf_jericalla = 1'b0;
    wait_until(c + 10);
    check_output("wrap_pc0", 32'(pc), 32'd0);
    check_output("wrap_branch_valid", 32'(instr_valid), 32'd0);
    wait_idle(60);

    repeat (3) @(negedge clk_jericalla);
    check_output("issue_queue_empty", 32'(issue_q.size()), 32'd0);
    check_output("done_queue_empty", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
